// File: rtl/dpram_be_clr_pkg.sv
// Shared definitions for the byte-enable dual-port RAM: FSM encodings,
// address-width sizing and the legal read-latency check.
package dpram_be_clr_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Bits needed to hold value; zero still needs one bit.
  function automatic int bitFit(input int value);
    int n;
    n = 1;
    for (int i = 1; i < 31; i++) begin
      if ((value >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

  function automatic bit legalRdLat(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Read-data/read-valid output registers for one RAM port, with an optional
// second stage when the read latency is two cycles.
module dpram_rd_pipe
  import dpram_be_clr_pkg::*;
#(
  parameter int DBW    = 32,
  parameter int RD_LAT = 1
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  input  logic           iValid,
  input  logic [DBW-1:0] iData,
  output logic           oValid,
  output logic [DBW-1:0] oData
);

  logic           s1ValidReg;
  logic [DBW-1:0] s1DataReg;

  // Data only loads on a strobe so the output holds between reads.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      s1ValidReg <= 1'b0;
      s1DataReg  <= '0;
    end else begin
      s1ValidReg <= iValid;
      if (iValid) s1DataReg <= iData;
    end
  end

  if (!legalRdLat(RD_LAT)) begin : g_badLat
    $error("dpram_rd_pipe: RD_LAT must be 1 or 2");
  end

  if (RD_LAT == 2) begin : g_lat2
    logic           s2ValidReg;
    logic [DBW-1:0] s2DataReg;

    always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
        s2ValidReg <= 1'b0;
        s2DataReg  <= '0;
      end else begin
        s2ValidReg <= s1ValidReg;
        if (s1ValidReg) s2DataReg <= s1DataReg;
      end
    end

    assign oValid = s2ValidReg;
    assign oData  = s2DataReg;
  end else begin : g_lat1
    assign oValid = s1ValidReg;
    assign oData  = s1DataReg;
  end

endmodule

// File: rtl/dpram_be_clr.sv
// Single-clock true dual-port RAM with byte enables, write-first reads,
// cross-port bypass, port-A-wins collisions and a post-reset clear sweep.
module dpram_be_clr
  import dpram_be_clr_pkg::*;
#(
  parameter int          DBW        = 32,
  parameter int          DEPTH      = 1023,
  parameter int          RD_LAT     = 1,
  parameter int          CLR_ON_RST = 1,
  parameter logic [DBW-1:0] INIT_VAL = '0,
  localparam int         ABW        = bitFit(DEPTH - 1),
  localparam int         NBE        = DBW / 8
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  output logic           oREADY,

  input  logic [ABW-1:0] iPA_ADDR,
  input  logic           iPA_WR,
  input  logic [NBE-1:0] iPA_BE,
  input  logic [DBW-1:0] iPA_WDATA,
  input  logic           iPA_RD,
  output logic [DBW-1:0] oPA_RDATA,
  output logic           oPA_RVALID,

  input  logic [ABW-1:0] iPB_ADDR,
  input  logic           iPB_WR,
  input  logic [NBE-1:0] iPB_BE,
  input  logic [DBW-1:0] iPB_WDATA,
  input  logic           iPB_RD,
  output logic [DBW-1:0] oPB_RDATA,
  output logic           oPB_RVALID
);

  logic [DBW-1:0] mem [DEPTH];

  state_t         stateReg, stateNext;
  logic [ABW-1:0] clrCntReg, clrCntNext;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      stateReg  <= ST_RST;
      clrCntReg <= '0;
    end else begin
      stateReg  <= stateNext;
      clrCntReg <= clrCntNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    clrCntNext = clrCntReg;
    case (stateReg)
      ST_RST: begin
        clrCntNext = '0;
        stateNext  = (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      end
      ST_CLEAR: begin
        clrCntNext = clrCntReg + 1'b1;
        if (clrCntReg == ABW'(DEPTH - 1)) stateNext = ST_RUN;
      end
      ST_RUN:  stateNext = ST_RUN;
      default: stateNext = ST_RST;
    endcase
  end

  assign oREADY = (stateReg == ST_RUN);

  logic           aInRange, bInRange, sameAddr;
  logic           aAcc, bAcc, aWrEn, bWrEn;
  logic [DBW-1:0] aOld, bOld, aNew, bNew;

  assign aInRange = int'(iPA_ADDR) < DEPTH;
  assign bInRange = int'(iPB_ADDR) < DEPTH;
  assign sameAddr = (iPA_ADDR == iPB_ADDR);
  assign aAcc     = oREADY & (iPA_WR | iPA_RD);
  assign bAcc     = oREADY & (iPB_WR | iPB_RD);
  assign aWrEn    = oREADY & iPA_WR & aInRange;
  assign bWrEn    = oREADY & iPB_WR & bInRange;
  assign aOld     = aInRange ? mem[iPA_ADDR] : '0;
  assign bOld     = bInRange ? mem[iPB_ADDR] : '0;

  // Each port sees the word after both ports' writes; A wins shared bytes,
  // so on a same-address collision aNew and bNew are identical.
  for (genvar gi = 0; gi < NBE; gi++) begin : g_byte
    always_comb begin
      if (aWrEn && iPA_BE[gi])
        aNew[8*gi +: 8] = iPA_WDATA[8*gi +: 8];
      else if (bWrEn && sameAddr && iPB_BE[gi])
        aNew[8*gi +: 8] = iPB_WDATA[8*gi +: 8];
      else
        aNew[8*gi +: 8] = aOld[8*gi +: 8];

      if (aWrEn && sameAddr && iPA_BE[gi])
        bNew[8*gi +: 8] = iPA_WDATA[8*gi +: 8];
      else if (bWrEn && iPB_BE[gi])
        bNew[8*gi +: 8] = iPB_WDATA[8*gi +: 8];
      else
        bNew[8*gi +: 8] = bOld[8*gi +: 8];
    end
  end

  always_ff @(posedge iCLK) begin
    if (stateReg == ST_CLEAR) begin
      mem[clrCntReg] <= INIT_VAL;
    end else begin
      if (aWrEn) mem[iPA_ADDR] <= aNew;
      if (bWrEn) mem[iPB_ADDR] <= bNew;
    end
  end

  dpram_rd_pipe #(.DBW(DBW), .RD_LAT(RD_LAT)) uPipeA (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iValid (aAcc),
    .iData  (aNew),
    .oValid (oPA_RVALID),
    .oData  (oPA_RDATA)
  );

  dpram_rd_pipe #(.DBW(DBW), .RD_LAT(RD_LAT)) uPipeB (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iValid (bAcc),
    .iData  (bNew),
    .oValid (oPB_RVALID),
    .oData  (oPB_RDATA)
  );

endmodule

// File: tb/tb_dpram_be_clr.sv
// Directed bench: a 16-word latency-1 instance with a visible clear value and
// a 1023-word latency-2 instance for out-of-range and pipeline checks.
module tb_dpram_be_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passCnt  = 0;
  int totalCnt = 0;

  // Instance 0: DEPTH=16, RD_LAT=1, INIT_VAL=A5A5A5A5
  logic        rst0N, rdy0;
  logic [3:0]  a0Addr, b0Addr, a0Be, b0Be;
  logic        a0Wr, a0Rd, b0Wr, b0Rd, a0Val, b0Val;
  logic [31:0] a0Wd, b0Wd, a0Rdat, b0Rdat;

  dpram_be_clr #(.DBW(32), .DEPTH(16), .RD_LAT(1), .CLR_ON_RST(1),
                 .INIT_VAL(32'hA5A5A5A5)) dut0 (
    .iCLK(clk), .iRST_N(rst0N), .oREADY(rdy0),
    .iPA_ADDR(a0Addr), .iPA_WR(a0Wr), .iPA_BE(a0Be), .iPA_WDATA(a0Wd),
    .iPA_RD(a0Rd), .oPA_RDATA(a0Rdat), .oPA_RVALID(a0Val),
    .iPB_ADDR(b0Addr), .iPB_WR(b0Wr), .iPB_BE(b0Be), .iPB_WDATA(b0Wd),
    .iPB_RD(b0Rd), .oPB_RDATA(b0Rdat), .oPB_RVALID(b0Val)
  );

  // Instance 1: DEPTH=1023, RD_LAT=2, INIT_VAL=0
  logic        rst1N, rdy1;
  logic [9:0]  a1Addr, b1Addr;
  logic [3:0]  a1Be, b1Be;
  logic        a1Wr, a1Rd, b1Wr, b1Rd, a1Val, b1Val;
  logic [31:0] a1Wd, b1Wd, a1Rdat, b1Rdat;

  dpram_be_clr #(.DBW(32), .DEPTH(1023), .RD_LAT(2), .CLR_ON_RST(1),
                 .INIT_VAL(32'h0)) dut1 (
    .iCLK(clk), .iRST_N(rst1N), .oREADY(rdy1),
    .iPA_ADDR(a1Addr), .iPA_WR(a1Wr), .iPA_BE(a1Be), .iPA_WDATA(a1Wd),
    .iPA_RD(a1Rd), .oPA_RDATA(a1Rdat), .oPA_RVALID(a1Val),
    .iPB_ADDR(b1Addr), .iPB_WR(b1Wr), .iPB_BE(b1Be), .iPB_WDATA(b1Wd),
    .iPB_RD(b1Rd), .oPB_RDATA(b1Rdat), .oPB_RVALID(b1Val)
  );

  typedef struct {
    logic        aWr, aRd;
    logic [3:0]  aBe, aAddr;
    logic [31:0] aWd;
    logic        bWr, bRd;
    logic [3:0]  bBe, bAddr;
    logic [31:0] bWd;
    logic        aVal;
    logic [31:0] aExp;
    logic        bVal;
    logic [31:0] bExp;
  } vec_t;

  function automatic vec_t mkVec(
    input logic aWr, aRd, input logic [3:0] aBe, aAddr, input logic [31:0] aWd,
    input logic bWr, bRd, input logic [3:0] bBe, bAddr, input logic [31:0] bWd,
    input logic aVal, input logic [31:0] aExp,
    input logic bVal, input logic [31:0] bExp);
    vec_t v;
    v.aWr = aWr; v.aRd = aRd; v.aBe = aBe; v.aAddr = aAddr; v.aWd = aWd;
    v.bWr = bWr; v.bRd = bRd; v.bBe = bBe; v.bAddr = bAddr; v.bWd = bWd;
    v.aVal = aVal; v.aExp = aExp; v.bVal = bVal; v.bExp = bExp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle0();
    a0Wr = 0; a0Rd = 0; b0Wr = 0; b0Rd = 0;
  endtask

  task automatic idle1();
    a1Wr = 0; a1Rd = 0; b1Wr = 0; b1Rd = 0;
  endtask

  // Counts edges from release until dut0 is ready; expects DEPTH+1 = 17.
  task automatic sweepCount0(input string name);
    int  cyc;
    bit  sawVal;
    cyc = 0;
    sawVal = 0;
    while (!rdy0 && cyc < 100) begin
      tick();
      cyc++;
      if (!rdy0 && (a0Val || b0Val)) sawVal = 1;
    end
    check(name, cyc, 17);
    check({name, "_noRvalid"}, {31'd0, sawVal}, 0);
  endtask

  vec_t vecs[13];

  initial begin
    int cyc;
    rst0N = 0; rst1N = 0;
    idle0(); idle1();
    a0Addr = 0; b0Addr = 0; a0Be = 0; b0Be = 0; a0Wd = 0; b0Wd = 0;
    a1Addr = 0; b1Addr = 0; a1Be = 0; b1Be = 0; a1Wd = 0; b1Wd = 0;

    vecs[0]  = mkVec(1,0,4'hF,4'd3,32'h11223344, 0,0,4'h0,4'd0,32'h0, 1,32'h11223344, 0,32'h0);
    vecs[1]  = mkVec(1,0,4'h5,4'd3,32'hAABBCCDD, 0,0,4'h0,4'd0,32'h0, 1,32'h11BB33DD, 0,32'h0);
    vecs[2]  = mkVec(0,1,4'h0,4'd3,32'h0, 0,1,4'h0,4'd0,32'h0, 1,32'h11BB33DD, 1,32'hA5A5A5A5);
    vecs[3]  = mkVec(1,0,4'h1,4'd5,32'h000000FF, 1,0,4'hF,4'd5,32'hFFFFFF00, 1,32'hFFFFFFFF, 1,32'hFFFFFFFF);
    vecs[4]  = mkVec(0,1,4'h0,4'd5,32'h0, 0,1,4'h0,4'd5,32'h0, 1,32'hFFFFFFFF, 1,32'hFFFFFFFF);
    vecs[5]  = mkVec(1,0,4'hF,4'd7,32'hDEADBEEF, 0,1,4'h0,4'd7,32'h0, 1,32'hDEADBEEF, 1,32'hDEADBEEF);
    vecs[6]  = mkVec(0,0,4'h0,4'd0,32'h0, 0,0,4'h0,4'd0,32'h0, 0,32'hDEADBEEF, 0,32'hDEADBEEF);
    vecs[7]  = mkVec(1,0,4'h0,4'd7,32'h0, 0,0,4'h0,4'd0,32'h0, 1,32'hDEADBEEF, 0,32'hDEADBEEF);
    vecs[8]  = mkVec(1,0,4'h3,4'd9,32'h12345678, 1,0,4'h6,4'd9,32'h9ABCDEF0, 1,32'hA5BC5678, 1,32'hA5BC5678);
    vecs[9]  = mkVec(0,1,4'h0,4'd9,32'h0, 0,1,4'h0,4'd9,32'h0, 1,32'hA5BC5678, 1,32'hA5BC5678);
    vecs[10] = mkVec(0,1,4'h0,4'd2,32'h0, 1,0,4'h8,4'd2,32'hCAFEBABE, 1,32'hCAA5A5A5, 1,32'hCAA5A5A5);
    vecs[11] = mkVec(0,1,4'h0,4'd15,32'h0, 0,1,4'h0,4'd14,32'h0, 1,32'hA5A5A5A5, 1,32'hA5A5A5A5);
    vecs[12] = mkVec(0,1,4'h0,4'd3,32'h0, 1,0,4'h2,4'd3,32'h0000EE00, 1,32'h11BBEEDD, 1,32'h11BBEEDD);

    @(negedge clk);
    tick(); tick();
    check("rst_ready", {31'd0, rdy0}, 0);
    check("rst_aValid", {31'd0, a0Val}, 0);
    check("rst_aData", a0Rdat, 0);
    check("rst_bValid", {31'd0, b0Val}, 0);
    check("rst_bData", b0Rdat, 0);

    // Drive a write+read on port A through the whole sweep; it must be ignored.
    a0Wr = 1; a0Rd = 1; a0Be = 4'hF; a0Addr = 0; a0Wd = 32'h0;
    rst0N = 1; rst1N = 1;
    sweepCount0("sweep_cycles");
    idle0();

    for (int i = 0; i < 16; i++) begin
      a0Rd = 1; a0Addr = 4'(i);
      tick();
      check($sformatf("clr_data%0d", i), a0Rdat, 32'hA5A5A5A5);
      check($sformatf("clr_valid%0d", i), {31'd0, a0Val}, 1);
    end
    idle0();

    foreach (vecs[i]) begin
      a0Wr = vecs[i].aWr; a0Rd = vecs[i].aRd; a0Be = vecs[i].aBe;
      a0Addr = vecs[i].aAddr; a0Wd = vecs[i].aWd;
      b0Wr = vecs[i].bWr; b0Rd = vecs[i].bRd; b0Be = vecs[i].bBe;
      b0Addr = vecs[i].bAddr; b0Wd = vecs[i].bWd;
      tick();
      $display("vec %0d: A %h/%0b B %h/%0b", i, a0Rdat, a0Val, b0Rdat, b0Val);
      check($sformatf("vec%0d_aValid", i), {31'd0, a0Val}, {31'd0, vecs[i].aVal});
      check($sformatf("vec%0d_aData", i), a0Rdat, vecs[i].aExp);
      check($sformatf("vec%0d_bValid", i), {31'd0, b0Val}, {31'd0, vecs[i].bVal});
      check($sformatf("vec%0d_bData", i), b0Rdat, vecs[i].bExp);
    end
    idle0();

    // Reset mid-sweep at word 8: sweep restarts and the full 17-cycle count repeats.
    rst0N = 0;
    tick();
    rst0N = 1;
    repeat (9) tick();
    rst0N = 0;
    tick();
    check("midsweep_ready", {31'd0, rdy0}, 0);
    rst0N = 1;
    sweepCount0("resweep_cycles");
    a0Rd = 1; a0Addr = 4'd3;
    tick();
    check("resweep_word3", a0Rdat, 32'hA5A5A5A5);
    idle0();

    cyc = 0;
    while (!rdy1 && cyc < 1200) begin
      tick();
      cyc++;
    end
    check("dut1_ready", {31'd0, rdy1}, 1);

    a1Wr = 1; a1Be = 4'hF; a1Addr = 10'd1022; a1Wd = 32'h12345678;
    tick(); idle1();
    check("lat2_wr1022_v1", {31'd0, a1Val}, 0);
    tick();
    check("lat2_wr1022_v2", {31'd0, a1Val}, 1);
    check("lat2_wr1022_d", a1Rdat, 32'h12345678);

    a1Wr = 1; a1Be = 4'hF; a1Addr = 10'd1023; a1Wd = 32'hFFFFFFFF;
    tick(); idle1(); tick();
    check("oor_wr_valid", {31'd0, a1Val}, 1);
    check("oor_wr_data", a1Rdat, 0);

    a1Rd = 1; a1Addr = 10'd1022;
    tick(); idle1(); tick();
    check("oor_word1022", a1Rdat, 32'h12345678);

    a1Rd = 1; a1Addr = 10'd1023;
    tick(); idle1(); tick();
    check("oor_rd_valid", {31'd0, a1Val}, 1);
    check("oor_rd_data", a1Rdat, 0);

    a1Wr = 1; a1Be = 4'hF; a1Addr = 10'd7; a1Wd = 32'hDEADBEEF;
    b1Rd = 1; b1Addr = 10'd7;
    tick(); idle1();
    check("lat2_bypass_v1", {31'd0, b1Val}, 0);
    tick();
    check("lat2_bypass_v2", {31'd0, b1Val}, 1);
    check("lat2_bypass_d", b1Rdat, 32'hDEADBEEF);

    // Read in flight when reset lands: it must never surface.
    a1Rd = 1; a1Addr = 10'd1022;
    tick(); idle1();
    rst1N = 0;
    tick();
    check("rst_pipe_v1", {31'd0, a1Val}, 0);
    tick();
    check("rst_pipe_v2", {31'd0, a1Val}, 0);
    check("rst_pipe_data", a1Rdat, 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
